// File: rtl/comparator_pkg.sv
// Shared definitions for the registered comparator: relation codes and default sizes.
package comparator_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_CNT_W = 8;

  typedef enum logic [2:0] {
    CMP_EQ  = 3'b000,
    CMP_NE  = 3'b001,
    CMP_LT  = 3'b010,
    CMP_LE  = 3'b011,
    CMP_GT  = 3'b100,
    CMP_GE  = 3'b101,
    CMP_SGT = 3'b110,
    CMP_SLT = 3'b111
  } cmp_mode_e;

endpackage

// File: rtl/comparator_core.sv
// Combinational relation evaluator: result = relation(a, thresh) selected by mode.
module comparator_core
  import comparator_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] thresh,
  input  logic [2:0]       mode,
  output logic             result
);

  always_comb begin
    result = 1'b0;
    case (mode)
      CMP_EQ:  result = (a == thresh);
      CMP_NE:  result = (a != thresh);
      CMP_LT:  result = (a <  thresh);
      CMP_LE:  result = (a <= thresh);
      CMP_GT:  result = (a >  thresh);
      CMP_GE:  result = (a >= thresh);
      // The last two codes treat both operands as two's complement
      CMP_SGT: result = ($signed(a) >  $signed(thresh));
      CMP_SLT: result = ($signed(a) <  $signed(thresh));
      default: result = 1'b0;
    endcase
  end

endmodule

// File: rtl/comparator_4b.sv
// Registered comparator with one-cycle latency and valid pipe.
// Optional saturating match counter enabled by macro COMPARATOR_COUNT_EN.
module comparator_4b
  import comparator_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
`ifdef COMPARATOR_COUNT_EN
  ,
  parameter int CNT_W = DEFAULT_CNT_W
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] thresh,
  input  logic [2:0]       mode,
  input  logic             valid_in,
  output logic             b,
  output logic             valid_out
`ifdef COMPARATOR_COUNT_EN
  ,
  output logic [CNT_W-1:0] match_cnt
`endif
);

  logic rel;
  logic b_q, b_d;
  logic valid_q, valid_d;

  comparator_core #(.WIDTH(WIDTH)) u_core (
    .a      (a),
    .thresh (thresh),
    .mode   (mode),
    .result (rel)
  );

  // b keeps its previous value across invalid cycles
  always_comb begin
    b_d     = valid_in ? rel : b_q;
    valid_d = valid_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b_q     <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      b_q     <= b_d;
      valid_q <= valid_d;
    end
  end

  assign b         = b_q;
  assign valid_out = valid_q;

`ifdef COMPARATOR_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturate at all-ones rather than wrapping
  always_comb begin
    cnt_d = cnt_q;
    if (valid_in && rel && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign match_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_comparator_4b.sv
// Self-checking bench for comparator_4b: directed vectors, literal checks and a per-cycle model compare.
module tb_comparator_4b;

  localparam int W = 4;
`ifdef COMPARATOR_COUNT_EN
  localparam int CW = 2;
`endif

  logic         clk;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] thresh;
  logic [2:0]   mode;
  logic         valid_in;
  logic         b;
  logic         valid_out;
`ifdef COMPARATOR_COUNT_EN
  logic [CW-1:0] match_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Model state
  bit model_known = 0;
  bit exp_b = 0;
  bit exp_v = 0;
  int exp_cnt = 0;

  comparator_4b #(
    .WIDTH(W)
`ifdef COMPARATOR_COUNT_EN
    , .CNT_W(CW)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .thresh    (thresh),
    .mode      (mode),
    .valid_in  (valid_in),
    .b         (b),
    .valid_out (valid_out)
`ifdef COMPARATOR_COUNT_EN
    , .match_cnt (match_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int to_signed(int v);
    return (v >= (1 << (W - 1))) ? v - (1 << W) : v;
  endfunction

  // Relation from the mode table using plain integer arithmetic
  function automatic bit model_rel(int av, int tv, int m);
    int sa = to_signed(av);
    int st = to_signed(tv);
    case (m)
      0: return av == tv;
      1: return av != tv;
      2: return av <  tv;
      3: return av <= tv;
      4: return av >  tv;
      5: return av >= tv;
      6: return sa >  st;
      default: return sa < st;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      exp_b = 0;
      exp_v = 0;
      exp_cnt = 0;
      model_known = 1;
    end else if (model_known) begin
      exp_v = valid_in;
      if (valid_in) begin
        exp_b = model_rel(int'(a), int'(thresh), int'(mode));
`ifdef COMPARATOR_COUNT_EN
        if (exp_b && exp_cnt < (1 << CW) - 1) exp_cnt = exp_cnt + 1;
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (model_known) begin
      checks++;
      if (b !== exp_b) begin
        errors++;
        $display("[TB] FAIL model_b at %0t: got %0b expected %0b", $time, b, exp_b);
      end
      checks++;
      if (valid_out !== exp_v) begin
        errors++;
        $display("[TB] FAIL model_valid at %0t: got %0b expected %0b", $time, valid_out, exp_v);
      end
`ifdef COMPARATOR_COUNT_EN
      checks++;
      if (int'(match_cnt) != exp_cnt) begin
        errors++;
        $display("[TB] FAIL model_cnt at %0t: got %0d expected %0d", $time, match_cnt, exp_cnt);
      end
`endif
    end
  end

  // Drive one input vector, then wait until its registered result is visible
  task automatic applyStimulus(input bit r, input int av, input int tv, input int m, input bit v);
    rst      = r;
    a        = W'(av);
    thresh   = W'(tv);
    mode     = 3'(m);
    valid_in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input bit want_b, input bit want_v);
    checks++;
    if (b !== want_b || valid_out !== want_v) begin
      errors++;
      $display("[TB] FAIL %s: got b=%0b valid_out=%0b expected b=%0b valid_out=%0b",
               name, b, valid_out, want_b, want_v);
    end
  endtask

`ifdef COMPARATOR_COUNT_EN
  task automatic checkCount(input string name, input int want);
    checks++;
    if (int'(match_cnt) != want) begin
      errors++;
      $display("[TB] FAIL %s: got match_cnt=%0d expected %0d", name, match_cnt, want);
    end
  endtask
`endif

  int seq_b[8] = '{1, 0, 0, 1, 0, 1, 0, 0};

  initial begin
    rst = 1'b1; a = '0; thresh = '0; mode = '0; valid_in = 1'b0;

    // Reset held with valid_in asserted
    applyStimulus(1, 5, 3, 4, 1);
    checkOutput("reset_cycle0", 0, 0);
    applyStimulus(1, 5, 3, 4, 1);
    checkOutput("reset_cycle1", 0, 0);
`ifdef COMPARATOR_COUNT_EN
    checkCount("reset_cnt", 0);
`endif

    // Unsigned GT sweep against 9
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, i, 9, 4, 1);
      checkOutput($sformatf("gt_sweep_a%0d", i), i >= 10, 1);
    end

    // Zero versus all-ones
    applyStimulus(0, 0, 15, 2, 1);
    checkOutput("zero_vs_ones_lt", 1, 1);
    applyStimulus(0, 0, 15, 6, 1);
    checkOutput("zero_vs_ones_sgt", 1, 1);
    applyStimulus(0, 0, 15, 7, 1);
    checkOutput("zero_vs_ones_slt", 0, 1);

    // MSB-only is the most negative signed value
    applyStimulus(0, 8, 7, 7, 1);
    checkOutput("msb_slt", 1, 1);
    applyStimulus(0, 8, 7, 2, 1);
    checkOutput("msb_lt", 0, 1);

    // Equal operands across every mode
    for (int m = 0; m < 8; m++) begin
      applyStimulus(0, 7, 7, m, 1);
      checkOutput($sformatf("equal_mode%0d", m), seq_b[m] != 0, 1);
    end

    // Valid toggling; the invalid cycle carries a false EQ to prove b holds
    applyStimulus(0, 3, 3, 0, 1);
    checkOutput("toggle_v1", 1, 1);
    applyStimulus(0, 1, 2, 0, 0);
    checkOutput("toggle_v0_hold", 1, 0);
    applyStimulus(0, 3, 3, 0, 1);
    checkOutput("toggle_v1_again", 1, 1);

`ifdef COMPARATOR_COUNT_EN
    applyStimulus(1, 0, 0, 0, 0);
    checkCount("cnt_clear", 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 2, 2, 0, 1);
      checkCount($sformatf("cnt_step%0d", i), (i < 3) ? i + 1 : 3);
    end
    applyStimulus(1, 2, 2, 0, 1);
    checkCount("cnt_rst_mid", 0);
    applyStimulus(0, 2, 2, 0, 1);
    checkCount("cnt_after_rst", 1);
`endif

    applyStimulus(0, 0, 0, 0, 0);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
